mem_sched: RTL

Single-port memory scheduler for the SISC core. Shares one combinational-read, synchronous-write 32-bit memory between two requesters: the instruction-fetch path (program counter side) and the load/store path (data side). Uses a registered request/grant/valid handshake, programmable wait states and a starvation guard. Sits between the control unit's fetch/memory-access sequencing and the memory array.

---
 rtl/mem_sched_if.sv | 37 +++
 rtl/mem_sched.sv | 120 ++++++++++++
 2 files changed

// File: rtl/mem_sched_if.sv
// Request/grant/valid bundle between the two SISC requesters, mem_sched and the memory array.
interface mem_sched_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_valid;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_valid;
  logic [DW-1:0] d_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           mem_addr, mem_wdata, mem_we, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           mem_addr, mem_wdata, mem_we, busy
  );
endinterface

// File: rtl/mem_sched.sv
// Single-port memory scheduler: fetch vs load/store, WAIT extra cycles per access, valid one cycle after ACC.
// MEM_SCHED_STARVE_EN enables the fetch starvation guard; otherwise data has strict priority.
module mem_sched #(
  parameter int AW     = 16,
  parameter int DW     = 32,
  parameter int WAIT   = 1,
  parameter int STARVE = 4
) (
  input  logic        clk,
  input  logic        rst_f,
  mem_sched_if.slave  bus
);
  if (WAIT < 0 || WAIT > 7 || STARVE < 1 || STARVE > 15) begin : g_bad_param
    $error("mem_sched: WAIT must be 0..7 and STARVE 1..15");
  end

  localparam logic [2:0] WAIT_C = WAIT[2:0];

  typedef enum logic {IDLE, ACC} state_t;
  state_t state, state_nxt;

  logic          own_d;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [2:0]    wcnt;
  logic          if_gnt_q, d_gnt_q, if_valid_q, d_valid_q;
  logic [DW-1:0] if_rdata_q, d_rdata_q;
  logic          grant_i, grant_d, done, starve_hit;

`ifdef MEM_SCHED_STARVE_EN
  localparam logic [3:0] STARVE_C = STARVE[3:0];
  logic [3:0] scnt;

  assign starve_hit = bus.if_req && (scnt == STARVE_C);

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      scnt <= '0;
    end else if (grant_i) begin
      scnt <= '0;
    end else if (grant_d) begin
      if (!bus.if_req)
        scnt <= '0;
      else if (scnt != STARVE_C)
        scnt <= scnt + 4'd1;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        grant_d = bus.d_req && !starve_hit;
        grant_i = bus.if_req && !grant_d;
        if (grant_d || grant_i) state_nxt = ACC;
      end
      ACC: begin
        done = (wcnt == 3'd0);
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      own_d      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wcnt       <= '0;
      if_gnt_q   <= 1'b0;
      d_gnt_q    <= 1'b0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if_gnt_q   <= grant_i;
      d_gnt_q    <= grant_d;
      if_valid_q <= done && !own_d;
      d_valid_q  <= done && own_d;
      if (grant_i || grant_d) begin
        own_d   <= grant_d;
        we_q    <= grant_d && bus.d_we;
        addr_q  <= grant_d ? bus.d_addr : bus.if_addr;
        wdata_q <= bus.d_wdata;
        wcnt    <= WAIT_C;
      end else if (state == ACC && wcnt != 3'd0) begin
        wcnt <= wcnt - 3'd1;
      end
      // Stores complete without touching d_rdata.
      if (done && !own_d)          if_rdata_q <= bus.mem_rdata;
      if (done && own_d && !we_q)  d_rdata_q  <= bus.mem_rdata;
    end
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = done && we_q;
  assign bus.busy      = (state == ACC);
endmodule
